// File: rtl/axi_line_bridge.sv
// axi_line_bridge: 128-bit cacheline responder turning one line read/write into a 2-beat 64-bit AXI4 INCR burst
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   valid/reqtyp/addr/wdata/size -> ready/rdata : cacheline request side (reqtyp 0 = read, 1 = write; size ignored)
//   o_axi_ar*/r*/aw*/w*/b* : AXI4 master channels, fixed len 1 (2 beats), size 8 bytes, INCR
//   o_err                : sticky response/rlast error flag, present only with AXI_LINE_BRIDGE_ERR_EN defined
module axi_line_bridge #(
  parameter int ADR_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
`ifdef AXI_LINE_BRIDGE_ERR_EN
  output logic                 o_err,
`endif
  input  logic                 valid,
  input  logic                 reqtyp,
  input  logic [ADR_WIDTH-1:0] addr,
  input  logic [127:0]         wdata,
  input  logic [1:0]           size,
  output logic                 ready,
  output logic [127:0]         rdata,
  output logic                 o_axi_arvalid,
  input  logic                 i_axi_arready,
  output logic [ADR_WIDTH-1:0] o_axi_araddr,
  output logic [7:0]           o_axi_arlen,
  output logic [2:0]           o_axi_arsize,
  output logic [1:0]           o_axi_arburst,
  input  logic                 i_axi_rvalid,
  output logic                 o_axi_rready,
  input  logic [63:0]          i_axi_rdata,
  input  logic [1:0]           i_axi_rresp,
  input  logic                 i_axi_rlast,
  output logic                 o_axi_awvalid,
  input  logic                 i_axi_awready,
  output logic [ADR_WIDTH-1:0] o_axi_awaddr,
  output logic [7:0]           o_axi_awlen,
  output logic [2:0]           o_axi_awsize,
  output logic [1:0]           o_axi_awburst,
  output logic                 o_axi_wvalid,
  input  logic                 i_axi_wready,
  output logic [63:0]          o_axi_wdata,
  output logic [7:0]           o_axi_wstrb,
  output logic                 o_axi_wlast,
  input  logic                 i_axi_bvalid,
  output logic                 o_axi_bready,
  input  logic [1:0]           i_axi_bresp
);
  localparam logic REQ_WRITE = 1'b1;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, RESP} state_t;
  state_t st, nxt;
  logic is_wr, beat;
  logic [ADR_WIDTH-1:0] addr_q;
  logic [127:0] wbuf, rbuf;
  logic unused_ok;
  assign unused_ok = ^{size, addr[3:0], i_axi_rresp, i_axi_rlast, i_axi_bresp};
  always_ff @(posedge i_clk) st <= !i_rst_n ? IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    if (valid) nxt = reqtyp == REQ_WRITE ? WADDR : RADDR;
      RADDR:   if (i_axi_arready) nxt = RDATA;
      RDATA:   if (i_axi_rvalid && beat) nxt = RESP;
      WADDR:   if (i_axi_awready) nxt = WDATA;
      WDATA:   if (i_axi_wready && beat) nxt = WRESP;
      WRESP:   if (i_axi_bvalid) nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    o_axi_arvalid = st == RADDR;
    o_axi_rready  = st == RDATA;
    o_axi_awvalid = st == WADDR;
    o_axi_wvalid  = st == WDATA;
    o_axi_wlast   = st == WDATA && beat;
    o_axi_bready  = st == WRESP;
    ready         = st == RESP;
    rdata         = st == RESP && !is_wr ? rbuf : '0;
    o_axi_araddr  = addr_q;
    o_axi_awaddr  = addr_q;
    o_axi_wdata   = beat ? wbuf[127:64] : wbuf[63:0];
    o_axi_wstrb   = 8'hff;
    o_axi_arlen   = 8'd1;
    o_axi_awlen   = 8'd1;
    o_axi_arsize  = 3'b011;
    o_axi_awsize  = 3'b011;
    o_axi_arburst = 2'b01;
    o_axi_awburst = 2'b01;
  end
  // One beat counter serves both directions; it wraps to 0 after the second beat.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      is_wr  <= 1'b0;
      addr_q <= '0;
      wbuf   <= '0;
      rbuf   <= '0;
      beat   <= 1'b0;
    end else begin
      if (st == IDLE && valid) begin
        is_wr  <= reqtyp == REQ_WRITE;
        addr_q <= {addr[ADR_WIDTH-1:4], 4'h0};
        wbuf   <= wdata;
        beat   <= 1'b0;
      end
      if (st == RDATA && i_axi_rvalid) begin
        beat <= ~beat;
        if (beat) rbuf[127:64] <= i_axi_rdata;
        else rbuf[63:0] <= i_axi_rdata;
      end
      if (st == WDATA && i_axi_wready) beat <= ~beat;
    end
  end
`ifdef AXI_LINE_BRIDGE_ERR_EN
  // rlast must be low on beat 0 and high on beat 1, i.e. equal to the beat index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_err <= 1'b0;
    else if ((st == RDATA && i_axi_rvalid && (i_axi_rresp != 2'b00 || i_axi_rlast != beat)) ||
             (st == WRESP && i_axi_bvalid && i_axi_bresp != 2'b00)) o_err <= 1'b1;
  end
`endif
endmodule
